axi_lite_master: RTL and testbench
==================================

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, max cycles waiting on any AXI handshake before abort (1..65535).
REQ-002 SHALL have ports:
 ACLK  in  1  clock, all logic on rising edge
 ARESETn  in  1  reset, asynchronous, active-low
 cmd_valid  in  1  command request
 cmd_ready  out  1  block can accept a command
 cmd_write  in  1  1 = write, 0 = read
 cmd_addr  in  32  target byte address
 cmd_wdata  in  32  write data
 rsp_valid  out  1  response available
 rsp_ready  in  1  response consumed
 rsp_rdata  out  32  read data (0 for writes)
 rsp_resp  out  2  BRESP/RRESP, forced 2'b10 on timeout
 rsp_timeout  out  1  transaction aborted by timeout
 AWVALID  out  1  write address valid
 AWREADY  in  1  write address ready
 AWADDR  out  32  write address
 WVALID  out  1  write data valid
 WREADY  in  1  write data ready
 WDATA  out  32  write data
 WSTRB  out  4  byte strobes, constant 4'b1111
 BVALID  in  1  write response valid
 BREADY  out  1  write response ready
 BRESP  in  2  write response code
 ARVALID  out  1  read address valid
 ARREADY  in  1  read address ready
 ARADDR  out  32  read address
 RVALID  in  1  read data valid
 RREADY  out  1  read data ready
 RDATA  in  32  read data
 RRESP  in  2  read response code
REQ-003 SHALL use one clock ACLK; reset ARESETn is asynchronous and active-low.

Function
REQ-004 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP; all outputs registered.
REQ-005 cmd_ready SHALL be 1 only in IDLE; command accepted on edge where cmd_valid & cmd_ready.
REQ-006 On accept, cmd_addr/cmd_wdata SHALL be latched; next cycle: write -> WR_REQ with AWVALID=WVALID=1; read -> RD_REQ with ARVALID=1.
REQ-007 AWVALID and WVALID SHALL each drop the cycle after their own handshake (VALID & READY at edge), independently; AWADDR/WDATA stable while VALID high.
REQ-008 Once both AW and W handshakes complete (same or different cycles), SHALL enter WR_RESP with BREADY=1 next cycle.
REQ-009 In WR_RESP, on BVALID & BREADY: capture BRESP into rsp_resp, rsp_rdata=0, BREADY=0, go RESP.
REQ-010 In RD_REQ, on ARVALID & ARREADY: ARVALID=0, RREADY=1, go RD_DATA.
REQ-011 In RD_DATA, on RVALID & RREADY: capture RDATA/RRESP, RREADY=0, go RESP.
REQ-012 In RESP, rsp_valid=1 with stable rsp_* until rsp_ready sampled 1; then rsp_valid=0, go IDLE; next command acceptable the following cycle.
REQ-013 Minimum latency against zero-wait slave: write accept edge N -> rsp_valid high after edge N+3; read accept edge N -> rsp_valid high after edge N+3.
REQ-014 SHALL never assert AWVALID/WVALID and ARVALID concurrently; one transaction outstanding at most.
REQ-015 16-bit timeout counter SHALL clear on entering WR_REQ/RD_REQ and on each handshake, increment every cycle in WR_REQ/WR_RESP/RD_REQ/RD_DATA.
REQ-016 When counter reaches TIMEOUT_CYCLES: all AXI VALID/READY outputs = 0 next cycle, rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0, go RESP.
REQ-017 A handshake in the same cycle the counter hits TIMEOUT_CYCLES SHALL take priority (no timeout).
REQ-018 rsp_timeout SHALL clear when the next command is accepted.

Reset
REQ-019 On ARESETn=0, immediately: state IDLE, cmd_ready=1, all AXI VALID/READY outputs 0, rsp_valid=0, rsp_timeout=0, rsp_rdata=0, rsp_resp=0, AWADDR/ARADDR/WDATA=0, counter 0.
REQ-020 Reset mid-transaction SHALL abort without response; first command after deassertion accepted normally.

Verification
REQ-021 Write 0x0000_0004/0xDEADBEEF, slave AWREADY=WREADY=BVALID=1, BRESP=00 -> AWADDR=0x4, WDATA=0xDEADBEEF, one-cycle handshakes, rsp_valid after edge N+3, rsp_resp=00.
REQ-022 Write, WREADY two cycles before AWREADY -> WVALID drops first, AWVALID held until AWREADY, BREADY only after both.
REQ-023 Read 0x0000_000C, ARREADY after 2 cycles, RDATA=0x12345678, RRESP=00 -> rsp_rdata=0x12345678; rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable.
REQ-024 TIMEOUT_CYCLES=8, read, ARREADY never asserted -> ARVALID drops after 8 cycles, rsp_timeout=1, rsp_resp=10, rsp_rdata=0.
REQ-025 ARESETn pulsed low during WR_RESP -> outputs at reset values asynchronously, no rsp_valid; subsequent read completes normally.

Source files
------------

// File: rtl/axi_lite_master.sv
// AXI4-Lite single-outstanding master.
// Turns one command (read or write) into the matching AXI4-Lite handshakes,
// aborts any handshake that stalls longer than TIMEOUT_CYCLES, and returns the
// result on a valid/ready response port. Every output comes from a flop.
module axi_lite_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] AWADDR,
    output logic        WVALID,
    input  logic        WREADY,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    input  logic        BVALID,
    output logic        BREADY,
    input  logic [1:0]  BRESP,
    output logic        ARVALID,
    input  logic        ARREADY,
    output logic [31:0] ARADDR,
    input  logic        RVALID,
    output logic        RREADY,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RESP    = 3'd5
    } state_t;

    // Abort threshold widened by one bit so the increment below never wraps.
    localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT_CYCLES);

    state_t      state_r, state_s;
    logic        cmd_ready_r, cmd_ready_s;
    logic        awvalid_r, awvalid_s;
    logic        wvalid_r, wvalid_s;
    logic        bready_r, bready_s;
    logic        arvalid_r, arvalid_s;
    logic        rready_r, rready_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] wdata_r, wdata_s;
    logic [15:0] cnt_r, cnt_s;
    logic        rsp_valid_r, rsp_valid_s;
    logic [31:0] rsp_rdata_r, rsp_rdata_s;
    logic [1:0]  rsp_resp_r, rsp_resp_s;
    logic        rsp_timeout_r, rsp_timeout_s;

    logic        aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
    logic [16:0] cnt_inc_s;
    logic        to_hit_s;
    logic        abort_s;

    assign aw_hs_s   = awvalid_r & AWREADY;
    assign w_hs_s    = wvalid_r & WREADY;
    assign b_hs_s    = bready_r & BVALID;
    assign ar_hs_s   = arvalid_r & ARREADY;
    assign r_hs_s    = rready_r & RVALID;
    assign cnt_inc_s = {1'b0, cnt_r} + 17'd1;
    assign to_hit_s  = (cnt_inc_s == TO_LIMIT);

    // Timeout abort: the wait counter hits its limit with no handshake this edge.
    always_comb begin
        abort_s = 1'b0;
        case (state_r)
            WR_REQ:  abort_s = to_hit_s & ~aw_hs_s & ~w_hs_s;
            WR_RESP: abort_s = to_hit_s & ~b_hs_s;
            RD_REQ:  abort_s = to_hit_s & ~ar_hs_s;
            RD_DATA: abort_s = to_hit_s & ~r_hs_s;
            default: abort_s = 1'b0;
        endcase
    end

    // Next state and next value of every registered output.
    always_comb begin
        state_s       = state_r;
        cmd_ready_s   = cmd_ready_r;
        awvalid_s     = awvalid_r;
        wvalid_s      = wvalid_r;
        bready_s      = bready_r;
        arvalid_s     = arvalid_r;
        rready_s      = rready_r;
        addr_s        = addr_r;
        wdata_s       = wdata_r;
        cnt_s         = cnt_r;
        rsp_valid_s   = rsp_valid_r;
        rsp_rdata_s   = rsp_rdata_r;
        rsp_resp_s    = rsp_resp_r;
        rsp_timeout_s = rsp_timeout_r;

        if (abort_s) begin
            awvalid_s     = 1'b0;
            wvalid_s      = 1'b0;
            bready_s      = 1'b0;
            arvalid_s     = 1'b0;
            rready_s      = 1'b0;
            cnt_s         = 16'd0;
            rsp_timeout_s = 1'b1;
            rsp_resp_s    = 2'b10;
            rsp_rdata_s   = 32'd0;
            state_s       = RESP;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid & cmd_ready_r) begin
                        addr_s        = cmd_addr;
                        wdata_s       = cmd_wdata;
                        cnt_s         = 16'd0;
                        rsp_timeout_s = 1'b0;
                        cmd_ready_s   = 1'b0;
                        if (cmd_write) begin
                            awvalid_s = 1'b1;
                            wvalid_s  = 1'b1;
                            state_s   = WR_REQ;
                        end else begin
                            arvalid_s = 1'b1;
                            state_s   = RD_REQ;
                        end
                    end else begin
                        cmd_ready_s = 1'b1;
                    end
                end
                WR_REQ: begin
                    // AW and W retire independently; B opens once both are gone.
                    awvalid_s = awvalid_r & ~aw_hs_s;
                    wvalid_s  = wvalid_r & ~w_hs_s;
                    if (aw_hs_s | w_hs_s) begin
                        cnt_s = 16'd0;
                        if (awvalid_s | wvalid_s) begin
                            state_s = WR_REQ;
                        end else begin
                            bready_s = 1'b1;
                            state_s  = WR_RESP;
                        end
                    end else begin
                        cnt_s = cnt_inc_s[15:0];
                    end
                end
                WR_RESP: begin
                    if (b_hs_s) begin
                        bready_s    = 1'b0;
                        cnt_s       = 16'd0;
                        rsp_resp_s  = BRESP;
                        rsp_rdata_s = 32'd0;
                        state_s     = RESP;
                    end else begin
                        cnt_s = cnt_inc_s[15:0];
                    end
                end
                RD_REQ: begin
                    if (ar_hs_s) begin
                        arvalid_s = 1'b0;
                        rready_s  = 1'b1;
                        cnt_s     = 16'd0;
                        state_s   = RD_DATA;
                    end else begin
                        cnt_s = cnt_inc_s[15:0];
                    end
                end
                RD_DATA: begin
                    if (r_hs_s) begin
                        rready_s    = 1'b0;
                        cnt_s       = 16'd0;
                        rsp_rdata_s = RDATA;
                        rsp_resp_s  = RRESP;
                        state_s     = RESP;
                    end else begin
                        cnt_s = cnt_inc_s[15:0];
                    end
                end
                RESP: begin
                    // First RESP cycle raises rsp_valid; it holds until consumed.
                    if (!rsp_valid_r) begin
                        rsp_valid_s = 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid_s = 1'b0;
                        cmd_ready_s = 1'b1;
                        state_s     = IDLE;
                    end else begin
                        rsp_valid_s = 1'b1;
                    end
                end
                default: begin
                    awvalid_s   = 1'b0;
                    wvalid_s    = 1'b0;
                    bready_s    = 1'b0;
                    arvalid_s   = 1'b0;
                    rready_s    = 1'b0;
                    rsp_valid_s = 1'b0;
                    cmd_ready_s = 1'b1;
                    state_s     = IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_r       <= IDLE;
            cmd_ready_r   <= 1'b1;
            awvalid_r     <= 1'b0;
            wvalid_r      <= 1'b0;
            bready_r      <= 1'b0;
            arvalid_r     <= 1'b0;
            rready_r      <= 1'b0;
            addr_r        <= 32'd0;
            wdata_r       <= 32'd0;
            cnt_r         <= 16'd0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= 32'd0;
            rsp_resp_r    <= 2'b00;
            rsp_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            cmd_ready_r   <= cmd_ready_s;
            awvalid_r     <= awvalid_s;
            wvalid_r      <= wvalid_s;
            bready_r      <= bready_s;
            arvalid_r     <= arvalid_s;
            rready_r      <= rready_s;
            addr_r        <= addr_s;
            wdata_r       <= wdata_s;
            cnt_r         <= cnt_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_rdata_r   <= rsp_rdata_s;
            rsp_resp_r    <= rsp_resp_s;
            rsp_timeout_r <= rsp_timeout_s;
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_resp    = rsp_resp_r;
    assign rsp_timeout = rsp_timeout_r;
    assign AWVALID     = awvalid_r;
    assign AWADDR      = addr_r;
    assign WVALID      = wvalid_r;
    assign WDATA       = wdata_r;
    assign WSTRB       = 4'b1111;
    assign BREADY      = bready_r;
    assign ARVALID     = arvalid_r;
    assign ARADDR      = addr_r;
    assign RREADY      = rready_r;

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: directed and random transactions
// against a slave with programmable per-channel delays; expected timing and
// results come from an edge-arithmetic reference model.
module tb_axi_lite_master;

    localparam int TO    = 8;
    localparam int NEVER = 100;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    int n_checks = 0;
    int n_errors = 0;

    axi_lite_master #(.TIMEOUT_CYCLES(TO)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. Edges are counted from the accept edge (edge 0); a
    // handshake channel with delay d completes d edges after its VALID/READY
    // first becomes visible. A wait longer than TO edges since the last
    // clearing event (phase entry or handshake) aborts at that bound.
    task automatic predict(input logic wr, input int da, input int dw, input int db,
                           output int rsp_t, output logic to,
                           output int a_cyc, output int w_cyc, output int b_cyc);
        int ea, ew, first, second, eb, et;
        et = -1; eb = 0; w_cyc = 0;
        if (wr) begin
            ea = 1 + da; ew = 1 + dw;
            first  = (ea < ew) ? ea : ew;
            second = (ea < ew) ? ew : ea;
            if (first > TO) et = TO;
            else if (second - first > TO) et = first + TO;
            else begin
                eb = second + 1 + db;
                if (eb - second > TO) et = second + TO;
            end
            if (et >= 0) begin
                to = 1'b1; rsp_t = et + 1;
                a_cyc = (ea < et) ? ea : et;
                w_cyc = (ew < et) ? ew : et;
                b_cyc = (et > second) ? et - second : 0;
            end else begin
                to = 1'b0; rsp_t = eb + 1;
                a_cyc = ea; w_cyc = ew; b_cyc = eb - second;
            end
        end else begin
            ea = 1 + da;
            if (ea > TO) et = TO;
            else begin
                eb = ea + 1 + db;
                if (eb - ea > TO) et = ea + TO;
            end
            if (et >= 0) begin
                to = 1'b1; rsp_t = et + 1;
                a_cyc = (ea < et) ? ea : et;
                b_cyc = (et > ea) ? et - ea : 0;
            end else begin
                to = 1'b0; rsp_t = eb + 1;
                a_cyc = ea; b_cyc = eb - ea;
            end
        end
    endtask

    // One transaction: for writes da/dw/db are AW/W/B delays, for reads da/db
    // are AR/R delays and data is what the slave returns on RDATA.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input int da, input int dw, input int db,
                           input logic [1:0] sresp, input int hold);
        int e_rsp_t, e_a, e_w, e_b;
        logic e_to;
        int wt = 0;
        int rsp_t = -1;
        int a_seen = 0, w_seen = 0, b_seen = 0;
        int a_cyc = 0, w_cyc = 0, b_cyc = 0;
        int hold_left = 0;
        logic got_a = 1'b0, got_w = 1'b0, done = 1'b0;
        logic overlap = 1'b0, bad_order = 1'b0, busy_ready = 1'b0, unstable = 1'b0;
        logic [31:0] cap_addr = 32'd0, cap_data = 32'd0, r_rdata = 32'd0;
        logic [3:0]  cap_strb = 4'd0;
        logic [1:0]  r_resp = 2'd0;
        logic        r_to = 1'b0;

        predict(wr, da, dw, db, e_rsp_t, e_to, e_a, e_w, e_b);

        while (!cmd_ready && wt < 50) begin
            @(negedge ACLK);
            wt++;
        end
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
        cmd_wdata = wr ? data : $urandom;
        @(negedge ACLK);
        cmd_valid = 1'b0;

        for (int t = 0; t < 300 && !done; t++) begin
            if ((AWVALID | WVALID) & ARVALID) overlap = 1'b1;
            if (BREADY & (AWVALID | WVALID)) bad_order = 1'b1;
            if (cmd_ready) busy_ready = 1'b1;
            if (wr) begin
                if (AWVALID) a_cyc++;
                if (WVALID)  w_cyc++;
                if (BREADY)  b_cyc++;
                AWREADY = AWVALID && (a_seen >= da);
                if (AWVALID) a_seen++;
                if (AWVALID && AWREADY) begin got_a = 1'b1; cap_addr = AWADDR; end
                WREADY = WVALID && (w_seen >= dw);
                if (WVALID) w_seen++;
                if (WVALID && WREADY) begin got_w = 1'b1; cap_data = WDATA; cap_strb = WSTRB; end
                BVALID = BREADY && (b_seen >= db);
                if (BREADY) b_seen++;
                BRESP = sresp;
            end else begin
                if (ARVALID) a_cyc++;
                if (RREADY)  b_cyc++;
                ARREADY = ARVALID && (a_seen >= da);
                if (ARVALID) a_seen++;
                if (ARVALID && ARREADY) begin got_a = 1'b1; cap_addr = ARADDR; end
                RVALID = RREADY && (b_seen >= db);
                if (RREADY) b_seen++;
                RDATA = data; RRESP = sresp;
            end
            if (rsp_valid) begin
                if (rsp_t < 0) begin
                    rsp_t = t; r_rdata = rsp_rdata; r_resp = rsp_resp; r_to = rsp_timeout;
                    hold_left = hold;
                end else if (rsp_rdata !== r_rdata || rsp_resp !== r_resp || rsp_timeout !== r_to) begin
                    unstable = 1'b1;
                end
                if (hold_left == 0) begin
                    rsp_ready = 1'b1; done = 1'b1;
                end else begin
                    rsp_ready = 1'b0; hold_left--;
                end
            end else begin
                if (rsp_t >= 0) unstable = 1'b1;
                rsp_ready = 1'b0;
            end
            @(negedge ACLK);
        end

        rsp_ready = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; ARREADY = 1'b0; RVALID = 1'b0;
        check("txn_done", 32'(done), 32'd1);
        check("rsp_valid_after_ack", 32'(rsp_valid), 32'd0);
        check("cmd_ready_after_ack", 32'(cmd_ready), 32'd1);
        check("rsp_latency", 32'(rsp_t), 32'(e_rsp_t));
        check("rsp_timeout", 32'(r_to), 32'(e_to));
        check("rsp_resp", 32'(r_resp), e_to ? 32'd2 : 32'(sresp));
        check("rsp_rdata", r_rdata, (wr || e_to) ? 32'd0 : data);
        check("addr_valid_cycles", 32'(a_cyc), 32'(e_a));
        check("resp_ready_cycles", 32'(b_cyc), 32'(e_b));
        if (got_a) check("axi_addr", cap_addr, addr);
        if (wr) begin
            check("wvalid_cycles", 32'(w_cyc), 32'(e_w));
            if (got_w) check("wdata", cap_data, data);
            if (got_w) check("wstrb", 32'(cap_strb), 32'hF);
        end
        check("wr_rd_overlap", 32'(overlap), 32'd0);
        check("bready_early", 32'(bad_order), 32'd0);
        check("cmd_ready_busy", 32'(busy_ready), 32'd0);
        check("rsp_stable", 32'(unstable), 32'd0);
    endtask

    function automatic int rnd_delay();
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 13) return r % 5;
        else if (r == 13) return 7;
        else if (r == 14) return 8;
        else return NEVER;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic seen;
        ARESETn = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0;
        rsp_ready = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = 32'd0; RRESP = 2'b00;
        #1 ARESETn = 1'b0;
        #2;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_axi_ctrl", 32'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_timeout, rsp_resp}), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_awaddr", AWADDR, 32'd0);
        check("rst_araddr", ARADDR, 32'd0);
        check("rst_wdata", WDATA, 32'd0);
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);

        // Directed cases
        run_txn(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 0, 0, 0, 2'b00, 0);
        run_txn(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 2, 0, 0, 2'b00, 1);
        run_txn(1'b0, 32'h0000_000C, 32'h1234_5678, 2, 0, 0, 2'b00, 5);
        run_txn(1'b0, 32'h0000_0020, 32'hABCD_0123, NEVER, 0, 0, 2'b00, 0);
        run_txn(1'b0, 32'h0000_0024, 32'h1111_2222, TO - 1, 0, 0, 2'b01, 0);
        run_txn(1'b0, 32'h0000_0028, 32'h3333_4444, 0, 0, TO, 2'b00, 0);
        run_txn(1'b1, 32'h0000_0030, 32'h5555_6666, 0, 0, TO - 1, 2'b11, 2);
        run_txn(1'b1, 32'h0000_0034, 32'h7777_8888, 0, 0, NEVER, 2'b00, 0);
        run_txn(1'b1, 32'h0000_0038, 32'h9999_AAAA, 0, NEVER, 0, 2'b00, 0);
        run_txn(1'b1, 32'h0000_003C, 32'hBBBB_CCCC, 3, 1, 2, 2'b10, 3);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom,
                    rnd_delay(), rnd_delay(), rnd_delay(),
                    2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Reset asserted while waiting for the write response
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0040; cmd_wdata = 32'h55AA_55AA;
        @(negedge ACLK);
        cmd_valid = 1'b0; AWREADY = 1'b1; WREADY = 1'b1;
        for (int i = 0; i < 20 && !BREADY; i++) @(negedge ACLK);
        check("rst_reach_wr_resp", 32'(BREADY), 32'd1);
        AWREADY = 1'b0; WREADY = 1'b0;
        #2 ARESETn = 1'b0;
        #1;
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_axi_ctrl", 32'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 32'd0);
        check("mid_rst_rsp", 32'({rsp_valid, rsp_timeout, rsp_resp}), 32'd0);
        check("mid_rst_awaddr", AWADDR, 32'd0);
        check("mid_rst_wdata", WDATA, 32'd0);
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge ACLK);
            if (rsp_valid) seen = 1'b1;
        end
        check("mid_rst_no_rsp", 32'(seen), 32'd0);
        run_txn(1'b0, 32'h0000_0080, 32'h0BAD_F00D, 0, 0, 0, 2'b00, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
